// File: rtl/fc_tcdm_responder.sv
// fc_tcdm_responder: slave end of the XBAR_TCDM_BUS req/gnt/r_valid protocol.
// Single-word requests are granted when not stalled, hit an internal
// word-addressed memory with byte-masked writes, and return one in-order
// response READ_LATENCY cycles after each grant edge.
// Optional build macro TCDM_RSP_ERR_EN: when defined, addresses outside
// [MEM_BASE, MEM_BASE + 4*MEM_WORDS) return an error response
// (r_opc_o=1, r_rdata_o=32'hBADA_CCE5) and leave memory untouched; when
// undefined, the address is not range-checked and aliases modulo the memory size.
module fc_tcdm_responder #(
   parameter int unsigned           ADDR_WIDTH   = 32,
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] MEM_BASE     = 32'h1C00_0000,
   parameter int unsigned           MEM_WORDS    = 1024,
   parameter int unsigned           READ_LATENCY = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_i,
   input  logic [ADDR_WIDTH-1:0]   add_i,
   input  logic                    wen_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic                    stall_i,
   output logic                    gnt_o,
   output logic                    r_valid_o,
   output logic [DATA_WIDTH-1:0]   r_rdata_o,
   output logic                    r_opc_o
);

   localparam int unsigned           IDX_W    = $clog2(MEM_WORDS);
   localparam int unsigned           BE_W     = DATA_WIDTH / 8;
   localparam logic [DATA_WIDTH-1:0] ERR_DATA = 32'hBADA_CCE5;

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   logic                  accept;
   logic [IDX_W-1:0]      idx;
   logic                  in_range;

   logic [DATA_WIDTH-1:0] s0_data;
   logic                  s0_opc;

   logic [READ_LATENCY-1:0] pipe_valid;
   logic [READ_LATENCY-1:0] pipe_opc;
   logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];

`ifdef TCDM_RSP_ERR_EN
   localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(4 * MEM_WORDS);

   logic [ADDR_WIDTH-1:0] off;
   logic                  unused_off;

   // Offset is only trusted once add_i >= MEM_BASE, so the subtraction cannot wrap.
   assign off        = add_i - MEM_BASE;
   assign in_range   = (add_i >= MEM_BASE) && ({1'b0, off} < SPAN);
   assign idx        = off[IDX_W+1:2];
   assign unused_off = ^off[1:0];
`else
   logic unused_add;
   logic unused_base;

   assign in_range    = 1'b1;
   assign idx         = add_i[IDX_W+1:2];
   assign unused_add  = ^{add_i[ADDR_WIDTH-1:IDX_W+2], add_i[1:0]};
   assign unused_base = ^MEM_BASE;
`endif

   // Grant is purely combinational; a grant always implies req_i.
   assign gnt_o  = req_i & ~stall_i & rst_ni;
   assign accept = gnt_o;

   // Stage-0 payload for the edge at hand: read data, error word or zero.
   always_comb begin
      s0_data = '0;
      s0_opc  = 1'b0;
      if (accept) begin
         if (!in_range) begin
            s0_data = ERR_DATA;
            s0_opc  = 1'b1;
         end else if (wen_i) begin
            s0_data = mem[idx];
         end
      end
   end

   // Byte-masked write into the storage array; contents are never reset.
   always_ff @(posedge clk_i) begin
      if (accept && !wen_i && in_range) begin
         for (int unsigned k = 0; k < BE_W; k++) begin
            if (be_i[k]) begin
               mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   // Fixed-latency response shift register; reset drops every in-flight response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pipe_valid <= '0;
         pipe_opc   <= '0;
         for (int unsigned s = 0; s < READ_LATENCY; s++) begin
            pipe_data[s] <= '0;
         end
      end else begin
         pipe_valid[0] <= accept;
         pipe_opc[0]   <= s0_opc;
         pipe_data[0]  <= s0_data;
         for (int unsigned s = 1; s < READ_LATENCY; s++) begin
            pipe_valid[s] <= pipe_valid[s-1];
            pipe_opc[s]   <= pipe_opc[s-1];
            pipe_data[s]  <= pipe_data[s-1];
         end
      end
   end

   assign r_valid_o = pipe_valid[READ_LATENCY-1];
   assign r_opc_o   = pipe_opc[READ_LATENCY-1];
   assign r_rdata_o = pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_fc_tcdm_responder.sv
// tb_fc_tcdm_responder: three responder instances (latency 1/3/4, sizes
// 1024/16/64 words) share one randomized request stream; a word-level
// reference model predicts every grant and every response slot.
module tb_fc_tcdm_responder;

   localparam logic [31:0] BASE = 32'h1C00_0000;
   localparam int unsigned NDUT = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic [31:0] add = '0;
   logic        wen = 1'b1;
   logic [31:0] wdata = '0;
   logic [3:0]  be = '0;
   logic        stall = 1'b0;

   logic [2:0]       gnt;
   logic [2:0]       rvalid;
   logic [2:0]       opc;
   logic [2:0][31:0] rdata;

   // reference model state
   logic [31:0] ref_mem   [NDUT][1024];
   bit          ref_known [NDUT][1024];
   bit          exp_v     [NDUT][16];
   bit          exp_o     [NDUT][16];
   bit          exp_dc    [NDUT][16];
   logic [31:0] exp_d     [NDUT][16];

   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   fc_tcdm_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BASE(BASE),
                       .MEM_WORDS(1024), .READ_LATENCY(1)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
      .wdata_i(wdata), .be_i(be), .stall_i(stall), .gnt_o(gnt[0]),
      .r_valid_o(rvalid[0]), .r_rdata_o(rdata[0]), .r_opc_o(opc[0]));

   fc_tcdm_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BASE(BASE),
                       .MEM_WORDS(16), .READ_LATENCY(3)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
      .wdata_i(wdata), .be_i(be), .stall_i(stall), .gnt_o(gnt[1]),
      .r_valid_o(rvalid[1]), .r_rdata_o(rdata[1]), .r_opc_o(opc[1]));

   fc_tcdm_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BASE(BASE),
                       .MEM_WORDS(64), .READ_LATENCY(4)) u_dut_c (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
      .wdata_i(wdata), .be_i(be), .stall_i(stall), .gnt_o(gnt[2]),
      .r_valid_o(rvalid[2]), .r_rdata_o(rdata[2]), .r_opc_o(opc[2]));

   function automatic int unsigned rl_of(input int unsigned d);
      case (d)
         0: return 1;
         1: return 3;
         default: return 4;
      endcase
   endfunction

   function automatic int unsigned words_of(input int unsigned d);
      case (d)
         0: return 1024;
         1: return 16;
         default: return 64;
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_pending();
      for (int unsigned d = 0; d < NDUT; d++) begin
         for (int unsigned s = 0; s < 16; s++) begin
            exp_v[d][s]  = 1'b0;
            exp_o[d][s]  = 1'b0;
            exp_dc[d][s] = 1'b0;
            exp_d[d][s]  = '0;
         end
      end
   endtask

   // What instance d does with the request accepted on the coming edge.
   task automatic model_accept(input int unsigned d);
      longint unsigned a, b, span;
      int unsigned     w, slot, i;
      bit              in_rng, err;
      logic [31:0]     rd;
      bit              dc;
      a      = longint'(add);
      b      = longint'(BASE);
      w      = words_of(d);
      span   = 4 * longint'(w);
      in_rng = (a >= b) && ((a - b) < span);
      err    = 1'b0;
      rd     = '0;
      dc     = 1'b0;
`ifdef TCDM_RSP_ERR_EN
      err = !in_rng;
      i   = in_rng ? int'((a - b) / 4) : 0;
`else
      i   = int'((a / 4) % longint'(w));
`endif
      if (err) begin
         rd = 32'hBADA_CCE5;
      end else if (wen) begin
         rd = ref_mem[d][i];
         dc = !ref_known[d][i];
      end else begin
         for (int unsigned k = 0; k < 4; k++)
            if (be[k]) ref_mem[d][i][8*k +: 8] = wdata[8*k +: 8];
         if (be == 4'hF) ref_known[d][i] = 1'b1;
      end
      slot = (cyc + rl_of(d)) % 16;
      exp_v[d][slot]  = 1'b1;
      exp_o[d][slot]  = err;
      exp_d[d][slot]  = rd;
      exp_dc[d][slot] = dc;
   endtask

   // One clock: drive inputs at the falling edge, predict, clock, check outputs.
   task automatic drive_cycle(input logic r, input logic q, input logic st, input logic we,
                              input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] bb);
      bit          acc;
      int unsigned s;
      rst_n = r; req = q; stall = st; wen = we; add = ad; wdata = wd; be = bb;
      if (!r) clear_pending();
      acc = r && q && !st;
      if (acc)
         for (int unsigned d = 0; d < NDUT; d++) model_accept(d);
      #1;
      for (int unsigned d = 0; d < NDUT; d++) begin
         check_eq($sformatf("gnt[%0d] cyc%0d", d, cyc), 32'(gnt[d]), 32'(acc));
         if (!r) begin
            check_eq($sformatf("rst_valid[%0d] cyc%0d", d, cyc), 32'(rvalid[d]), 32'd0);
            check_eq($sformatf("rst_rdata[%0d] cyc%0d", d, cyc), rdata[d], 32'd0);
            check_eq($sformatf("rst_opc[%0d] cyc%0d", d, cyc), 32'(opc[d]), 32'd0);
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      s = cyc % 16;
      for (int unsigned d = 0; d < NDUT; d++) begin
         check_eq($sformatf("r_valid[%0d] cyc%0d", d, cyc), 32'(rvalid[d]), 32'(exp_v[d][s]));
         check_eq($sformatf("r_opc[%0d] cyc%0d", d, cyc), 32'(opc[d]), 32'(exp_o[d][s]));
         if (!exp_dc[d][s])
            check_eq($sformatf("r_rdata[%0d] cyc%0d", d, cyc), rdata[d], exp_d[d][s]);
         exp_v[d][s]  = 1'b0;
         exp_o[d][s]  = 1'b0;
         exp_dc[d][s] = 1'b0;
         exp_d[d][s]  = '0;
      end
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned j = 0; j < n; j++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0);
   endtask

   task automatic wr(input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] bb);
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, ad, wd, bb);
   endtask

   task automatic rd(input logic [31:0] ad);
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, ad, $urandom(), 4'($urandom()));
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0: return BASE - 32'(4 * $urandom_range(1, 4));
         1: return BASE + 32'(64 + 4 * $urandom_range(0, 3));
         2: return BASE + 32'(4 * 64 - 4 * $urandom_range(0, 1));
         3: return BASE + 32'(4 * 1024 - 4 + 4 * $urandom_range(0, 1));
         4: return $urandom();
         default: return BASE + 32'(4 * $urandom_range(0, 15) + $urandom_range(0, 3));
      endcase
   endfunction

   initial begin
      for (int unsigned d = 0; d < NDUT; d++)
         for (int unsigned i = 0; i < 1024; i++) begin
            ref_mem[d][i]   = '0;
            ref_known[d][i] = 1'b0;
         end
      clear_pending();
      @(negedge clk);

      // held in reset with a request pending: no grant, quiet outputs
      for (int unsigned j = 0; j < 3; j++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, BASE, '0, '0);
      idle(2);

      // preload words 0..15 with 0xA0..0xAF
      for (int unsigned i = 0; i < 16; i++) wr(BASE + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
      idle(4);

      // full write, read back, byte-masked write, read back
      wr(32'h1C00_0010, 32'hDEAD_BEEF, 4'hF);
      rd(32'h1C00_0010);
      wr(32'h1C00_0010, 32'h1122_3344, 4'b0101);
      rd(32'h1C00_0013);
      wr(32'h1C00_0010, 32'hFFFF_FFFF, 4'b0000);
      rd(32'h1C00_0010);
      idle(4);

      // stalled request for three cycles, then granted
      for (int unsigned j = 0; j < 3; j++)
         drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h1C00_0010, '0, '0);
      rd(32'h1C00_0010);
      idle(5);

      // back-to-back reads of words 0..3
      for (int unsigned i = 0; i < 4; i++) rd(BASE + 32'(4 * i));
      idle(5);

      // one past the largest memory: error or alias onto word 0
      wr(32'h1C00_1000, 32'h5555_AAAA, 4'hF);
      rd(BASE);
      rd(32'h1C00_1000);
      idle(5);

      // range boundaries
      wr(BASE + 32'(4 * 16), 32'h0000_0B16, 4'hF);
      rd(BASE + 32'(4 * 16));
      wr(BASE + 32'(4 * 64 - 4), 32'h0000_0C3F, 4'hF);
      rd(BASE + 32'(4 * 64 - 4));
      wr(BASE + 32'(4 * 1024 - 4), 32'h0000_0A3F, 4'hF);
      rd(BASE + 32'(4 * 1024 - 4));
      wr(BASE - 32'd4, 32'h0000_BEF0, 4'hF);
      rd(BASE - 32'd4);
      rd(32'hFFFF_FFFC);
      rd(BASE);
      idle(5);

      // reset lands before the first of two read responses reaches the slowest instance
      rd(BASE);
      rd(BASE + 32'd4);
      idle(1);
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, BASE, '0, '0);
      idle(6);
      rd(BASE);
      rd(BASE + 32'd4);
      idle(5);

      // randomized traffic with occasional resets
      for (int unsigned j = 0; j < 3000; j++) begin
         drive_cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 3) == 0), 1'($urandom()), rand_addr(),
                     $urandom(), 4'($urandom()));
      end
      idle(6);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
